// File: rtl/plic_pkg.sv
// Types shared by the interrupt gateway array, the priority tree wrapper and the controller core.
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE      = 2'b00,
    GW_PENDING   = 2'b01,
    GW_IN_FLIGHT = 2'b10
  } gateway_state_t;

endpackage

// File: rtl/plic_gateway.sv
// Single-source interrupt gateway: holds one request from arrival through claim to completion.
// PLIC_EDGE_TRIGGER_EN adds per-source rising-edge mode with a deferred re-pend bit.
module plic_gateway
  import plic_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic irq_s,
`ifdef PLIC_EDGE_TRIGGER_EN
  input  logic edge_mode,
`endif
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending,
  output logic in_flight
);

  gateway_state_t state_reg, state_next;
  logic           trigger;

`ifdef PLIC_EDGE_TRIGGER_EN
  logic irq_prev_reg;
  logic deferred_reg, deferred_next;
  logic rise;

  assign rise    = irq_s & ~irq_prev_reg;
  assign trigger = edge_mode ? rise : irq_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_prev_reg <= 1'b0;
      deferred_reg <= 1'b0;
    end else begin
      irq_prev_reg <= irq_s;
      deferred_reg <= deferred_next;
    end
  end
`else
  assign trigger = irq_s;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= GW_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
`ifdef PLIC_EDGE_TRIGGER_EN
    deferred_next = deferred_reg;
`endif
    case (state_reg)
      GW_IDLE: begin
        if (trigger) state_next = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim_hit) state_next = GW_IN_FLIGHT;
      end
      GW_IN_FLIGHT: begin
        if (complete_hit) begin
`ifdef PLIC_EDGE_TRIGGER_EN
          // An edge landing on the completing cycle is kept rather than lost.
          state_next    = (deferred_reg || (edge_mode && rise)) ? GW_PENDING : GW_IDLE;
          deferred_next = 1'b0;
`else
          state_next = GW_IDLE;
`endif
        end
`ifdef PLIC_EDGE_TRIGGER_EN
        else if (edge_mode && rise) begin
          deferred_next = 1'b1;
        end
`endif
      end
      default: state_next = GW_IDLE;
    endcase
  end

  assign pending   = (state_reg == GW_PENDING);
  assign in_flight = (state_reg == GW_IN_FLIGHT);

endmodule

// File: rtl/plic_gateway_array.sv
// N interrupt gateways with input synchronisers and claim/complete index decode; feeds the priority tree.
// PLIC_EDGE_TRIGGER_EN adds the i_edge port selecting rising-edge mode per source.
module plic_gateway_array
  import plic_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_irq,
  input  logic [N-1:0]         i_enable,
  input  logic                 i_claim,
  input  logic [$clog2(N)-1:0] i_claim_index,
  input  logic                 i_complete,
  input  logic [$clog2(N)-1:0] i_complete_index,
`ifdef PLIC_EDGE_TRIGGER_EN
  input  logic [N-1:0]         i_edge,
`endif
  output logic [N-1:0]         o_pending,
  output logic [N-1:0]         o_in_flight
);

  localparam int M = $clog2(N);

  logic [N-1:0] sync_reg [SYNC_STAGES];
  logic [N-1:0] irq_s;
  logic [N-1:0] pending_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= i_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  assign irq_s = sync_reg[SYNC_STAGES-1];

  // Indices at or above N match no gateway, so such strobes fall away here.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gw
      logic claim_hit, complete_hit;

      assign claim_hit    = i_claim    && (i_claim_index    == M'(gi));
      assign complete_hit = i_complete && (i_complete_index == M'(gi));

      plic_gateway u_gw (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .irq_s        (irq_s[gi]),
`ifdef PLIC_EDGE_TRIGGER_EN
        .edge_mode    (i_edge[gi]),
`endif
        .claim_hit    (claim_hit),
        .complete_hit (complete_hit),
        .pending      (pending_state[gi]),
        .in_flight    (o_in_flight[gi])
      );
    end
  endgenerate

  // Masking after the state register lets a re-enabled source show its held request at once.
  assign o_pending = pending_state & i_enable;

endmodule

// File: tb/tb_plic_gateway_array.sv
// Bench for plic_gateway_array: directed vector table, N=3 index corner, randomized run against a
// request-level reference model, and an edge-mode sequence when PLIC_EDGE_TRIGGER_EN is defined.
module tb_plic_gateway_array;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq, en, pend, infl, edge_sel;
  logic       claim, comp;
  logic [1:0] cidx, pidx;

  logic [2:0] irq3, en3, pend3, infl3, edge3;
  logic       claim3, comp3;
  logic [1:0] cidx3, pidx3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plic_gateway_array #(.N(4), .SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_enable(en),
    .i_claim(claim), .i_claim_index(cidx),
    .i_complete(comp), .i_complete_index(pidx),
`ifdef PLIC_EDGE_TRIGGER_EN
    .i_edge(edge_sel),
`endif
    .o_pending(pend), .o_in_flight(infl)
  );

  plic_gateway_array #(.N(3), .SYNC_STAGES(S)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_irq(irq3), .i_enable(en3),
    .i_claim(claim3), .i_claim_index(cidx3),
    .i_complete(comp3), .i_complete_index(pidx3),
`ifdef PLIC_EDGE_TRIGGER_EN
    .i_edge(edge3),
`endif
    .o_pending(pend3), .o_in_flight(infl3)
  );

  // Reference model: requests held per source as booleans, irq delayed through a history list.
  logic [3:0] m_hist [S];
  logic [3:0] m_pend, m_infl;

  task automatic model_step();
    logic [3:0] seen;
    if (rst) begin
      for (int k = 0; k < S; k++) m_hist[k] = '0;
      m_pend = '0;
      m_infl = '0;
    end else begin
      seen = m_hist[S-1];
      for (int i = 0; i < 4; i++) begin
        if (m_infl[i]) begin
          if (comp && pidx == i) m_infl[i] = 1'b0;
        end else if (m_pend[i]) begin
          if (claim && cidx == i) begin
            m_pend[i] = 1'b0;
            m_infl[i] = 1'b1;
          end
        end else if (seen[i]) begin
          m_pend[i] = 1'b1;
        end
      end
      for (int k = S-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    claim = 1'b0; cidx = '0; comp = 1'b0; pidx = '0;
  endtask

  typedef struct {
    logic [3:0] irq;
    logic [3:0] en;
    logic       cl;
    logic [1:0] ci;
    logic       co;
    logic [1:0] pi;
    logic [3:0] ep;
    logic [3:0] ei;
  } vec_t;

  function automatic vec_t v(logic [3:0] i, logic [3:0] e, logic c, logic [1:0] ci,
                             logic o, logic [1:0] pi, logic [3:0] ep, logic [3:0] ei);
    vec_t r;
    r.irq = i; r.en = e; r.cl = c; r.ci = ci; r.co = o; r.pi = pi; r.ep = ep; r.ei = ei;
    return r;
  endfunction

  vec_t tbl [32];

  initial begin
    tbl[0]  = v(4'b0101, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[1]  = v(4'b0101, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[2]  = v(4'b0101, 4'b1111, 0, 0, 0, 0, 4'b0101, 4'b0000);
    tbl[3]  = v(4'b0101, 4'b1111, 1, 2, 0, 0, 4'b0001, 4'b0100);
    tbl[4]  = v(4'b0101, 4'b1111, 1, 1, 0, 0, 4'b0001, 4'b0100);
    tbl[5]  = v(4'b0101, 4'b1111, 0, 0, 1, 2, 4'b0001, 4'b0000);
    tbl[6]  = v(4'b0101, 4'b1111, 0, 0, 0, 0, 4'b0101, 4'b0000);
    tbl[7]  = v(4'b0101, 4'b1111, 1, 2, 0, 0, 4'b0001, 4'b0100);
    tbl[8]  = v(4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0100);
    tbl[9]  = v(4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0100);
    tbl[10] = v(4'b0001, 4'b1111, 0, 0, 1, 2, 4'b0001, 4'b0000);
    tbl[11] = v(4'b0001, 4'b1111, 0, 0, 1, 1, 4'b0001, 4'b0000);
    tbl[12] = v(4'b0101, 4'b1111, 0, 0, 1, 0, 4'b0001, 4'b0000);
    tbl[13] = v(4'b0101, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[14] = v(4'b0101, 4'b1111, 0, 0, 0, 0, 4'b0101, 4'b0000);
    tbl[15] = v(4'b0101, 4'b1011, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[16] = v(4'b0001, 4'b1011, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[17] = v(4'b0001, 4'b1111, 0, 0, 0, 0, 4'b0101, 4'b0000);
    tbl[18] = v(4'b0001, 4'b1111, 1, 2, 0, 0, 4'b0001, 4'b0100);
    tbl[19] = v(4'b0001, 4'b1111, 1, 0, 1, 2, 4'b0000, 4'b0001);
    tbl[20] = v(4'b0000, 4'b1111, 0, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[21] = v(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b0000);
    tbl[22] = v(4'b0000, 4'b1111, 1, 0, 0, 0, 4'b0000, 4'b0001);
    tbl[23] = v(4'b0000, 4'b1111, 0, 0, 1, 0, 4'b0000, 4'b0000);
    tbl[24] = v(4'b1000, 4'b0111, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[25] = v(4'b1000, 4'b0111, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[26] = v(4'b1000, 4'b0111, 0, 0, 0, 0, 4'b0000, 4'b0000);
    tbl[27] = v(4'b1000, 4'b0111, 1, 3, 0, 0, 4'b0000, 4'b1000);
    tbl[28] = v(4'b0000, 4'b0111, 0, 0, 1, 3, 4'b0000, 4'b0000);
    tbl[29] = v(4'b0000, 4'b1111, 0, 0, 0, 0, 4'b1000, 4'b0000);
    tbl[30] = v(4'b0000, 4'b1111, 1, 3, 0, 0, 4'b0000, 4'b1000);
    tbl[31] = v(4'b0000, 4'b1111, 0, 0, 1, 3, 4'b0000, 4'b0000);

    // Reset with irq already high: outputs must stay low while reset is held.
    rst = 1'b1; irq = 4'b0101; en = 4'b1111; edge_sel = '0; idle();
    irq3 = '0; en3 = 3'b111; edge3 = '0; claim3 = 1'b0; cidx3 = '0; comp3 = 1'b0; pidx3 = '0;
    tick();
    tick();
    chk("reset_pending", pend, 4'b0000);
    chk("reset_in_flight", infl, 4'b0000);
    $display("reset pend=%b infl=%b", pend, infl);
    rst = 1'b0;

    for (int r = 0; r < 32; r++) begin
      irq = tbl[r].irq; en = tbl[r].en;
      claim = tbl[r].cl; cidx = tbl[r].ci; comp = tbl[r].co; pidx = tbl[r].pi;
      tick();
      $display("vec %0d irq=%b en=%b claim=%b/%0d comp=%b/%0d pend=%b infl=%b",
               r, irq, en, claim, cidx, comp, pidx, pend, infl);
      chk($sformatf("vec%0d_pending", r), pend, tbl[r].ep);
      chk($sformatf("vec%0d_in_flight", r), infl, tbl[r].ei);
    end
    idle();

    // N=3: index 3 matches no source.
    rst = 1'b1; irq3 = 3'b111; tick();
    rst = 1'b0; tick(); tick(); tick();
    chk("n3_pending", {1'b0, pend3}, 4'b0111);
    claim3 = 1'b1; cidx3 = 2'd3; tick();
    $display("n3 claim idx3 pend=%b infl=%b", pend3, infl3);
    chk("n3_claim3_pending", {1'b0, pend3}, 4'b0111);
    chk("n3_claim3_in_flight", {1'b0, infl3}, 4'b0000);
    claim3 = 1'b0; comp3 = 1'b1; pidx3 = 2'd3; tick();
    chk("n3_complete3_in_flight", {1'b0, infl3}, 4'b0000);
    comp3 = 1'b0; claim3 = 1'b1; cidx3 = 2'd2; tick();
    $display("n3 claim idx2 pend=%b infl=%b", pend3, infl3);
    chk("n3_claim2_pending", {1'b0, pend3}, 4'b0011);
    chk("n3_claim2_in_flight", {1'b0, infl3}, 4'b0100);
    claim3 = 1'b0;

    // Randomized traffic against the reference model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      en    = 4'($urandom) | 4'($urandom);
      claim = ($urandom_range(0, 1) == 1);
      cidx  = 2'($urandom);
      comp  = ($urandom_range(0, 1) == 1);
      pidx  = 2'($urandom);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
      $display("rnd %0d rst=%b irq=%b en=%b claim=%b/%0d comp=%b/%0d pend=%b infl=%b",
               c, rst, irq, en, claim, cidx, comp, pidx, pend, infl);
      chk($sformatf("rnd%0d_pending", c), pend, m_pend & en);
      chk($sformatf("rnd%0d_in_flight", c), infl, m_infl);
    end
    rst = 1'b0; idle(); irq = '0; en = 4'b1111;

`ifdef PLIC_EDGE_TRIGGER_EN
    // Edge source 1: pulse, claim, pulse while in flight, complete -> re-pends.
    rst = 1'b1; edge_sel = 4'b0010; tick(); rst = 1'b0;
    irq = 4'b0010; tick(); irq = '0; tick(); tick();
    chk("edge_first_pending", pend, 4'b0010);
    claim = 1'b1; cidx = 2'd1; tick(); idle();
    chk("edge_claim_in_flight", infl, 4'b0010);
    irq = 4'b0010; tick(); irq = '0; tick(); tick();
    chk("edge_deferred_in_flight", infl, 4'b0010);
    comp = 1'b1; pidx = 2'd1; tick(); idle();
    $display("edge complete pend=%b infl=%b", pend, infl);
    chk("edge_deferred_repend", pend, 4'b0010);
    chk("edge_deferred_done", infl, 4'b0000);
    // Two pulses while pending merge into one request.
    irq = 4'b0010; tick(); irq = '0; tick();
    irq = 4'b0010; tick(); irq = '0; tick(); tick(); tick();
    claim = 1'b1; cidx = 2'd1; tick(); idle();
    comp = 1'b1; pidx = 2'd1; tick(); idle();
    tick();
    $display("edge merged pend=%b infl=%b", pend, infl);
    chk("edge_merged_pending", pend, 4'b0000);
    chk("edge_merged_in_flight", infl, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
